// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples asynchronous SCK/LRCK/SD with clkin and deserialises each
// Philips-format stereo frame into one {left, right} word with a one-cycle valid strobe.
module i2s_rx #(
  parameter int unsigned WORD_BITS = 16,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                   clkin,
  input  logic                   rst,
  input  logic                   sck,
  input  logic                   lrck,
  input  logic                   sd,
  output logic [2*WORD_BITS-1:0] sound,
  output logic                   valid,
  output logic                   error
);

  localparam int unsigned CntW = $clog2(WORD_BITS + 2);
  localparam int unsigned ToW  = $clog2(TIMEOUT + 1);

  localparam logic [CntW-1:0] CntSat  = CntW'(WORD_BITS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WORD_BITS - 1);
  localparam logic [ToW-1:0]  ToMax   = ToW'(TIMEOUT);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StHunt, StLeft, StRight} state_e;

  state_e                 state_q, state_d;
  logic                   sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_prev_q, sck_prev_d;
  logic                   lrck_meta_q, lrck_meta_d, lrck_sync_q, lrck_sync_d;
  logic                   sd_meta_q, sd_meta_d, sd_sync_q, sd_sync_d;
  logic                   lrck_last_q, lrck_last_d;
  logic [WORD_BITS-1:0]   shift_q, shift_d;
  logic [WORD_BITS-1:0]   left_q, left_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [ToW-1:0]         to_q, to_d;
  logic [2*WORD_BITS-1:0] sound_q, sound_d;
  logic                   valid_q, valid_d, error_q, error_d;

  logic                   rise, boundary, slot_full;
  logic [WORD_BITS-1:0]   word;

  always_comb begin
    sck_meta_d  = sck;
    sck_sync_d  = sck_meta_q;
    sck_prev_d  = sck_sync_q;
    lrck_meta_d = lrck;
    lrck_sync_d = lrck_meta_q;
    sd_meta_d   = sd;
    sd_sync_d   = sd_meta_q;

    rise      = sck_sync_q & ~sck_prev_q;
    boundary  = rise && (lrck_sync_q != lrck_last_q);
    slot_full = (cnt_q == CntLast);
    // The boundary bit is the LSB of the slot that just ended.
    word      = {shift_q[WORD_BITS-2:0], sd_sync_q};

    lrck_last_d = rise ? lrck_sync_q : lrck_last_q;
    shift_d     = rise ? word : shift_q;
    to_d        = rise ? '0 : ((to_q == ToMax) ? to_q : to_q + ToW'(1));

    state_d = state_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    sound_d = sound_q;
    valid_d = 1'b0;
    error_d = 1'b0;

    if (rise) begin
      if (!boundary) begin
        cnt_d = (cnt_q == CntSat) ? cnt_q : cnt_q + CntW'(1);
      end else begin
        cnt_d = '0;
        unique case (state_q)
          StHunt: begin
            if (!lrck_sync_q) state_d = StLeft;
          end
          StLeft: begin
            if (slot_full && lrck_sync_q) begin
              left_d  = word;
              state_d = StRight;
            end else begin
              error_d = 1'b1;
              state_d = lrck_sync_q ? StHunt : StLeft;
            end
          end
          StRight: begin
            if (slot_full && !lrck_sync_q) begin
              sound_d = {left_q, word};
              valid_d = 1'b1;
              state_d = StLeft;
            end else begin
              // A 1->0 boundary starts a fresh left slot, so resync without hunting.
              error_d = 1'b1;
              state_d = lrck_sync_q ? StHunt : StLeft;
            end
          end
          default: state_d = StHunt;
        endcase
      end
    end else if ((state_q != StHunt) && (to_q == ToLast)) begin
      error_d = 1'b1;
      state_d = StHunt;
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q     <= StHunt;
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      lrck_meta_q <= 1'b0;
      lrck_sync_q <= 1'b0;
      sd_meta_q   <= 1'b0;
      sd_sync_q   <= 1'b0;
      lrck_last_q <= 1'b0;
      shift_q     <= '0;
      left_q      <= '0;
      cnt_q       <= '0;
      to_q        <= '0;
      sound_q     <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_meta_q  <= sck_meta_d;
      sck_sync_q  <= sck_sync_d;
      sck_prev_q  <= sck_prev_d;
      lrck_meta_q <= lrck_meta_d;
      lrck_sync_q <= lrck_sync_d;
      sd_meta_q   <= sd_meta_d;
      sd_sync_q   <= sd_sync_d;
      lrck_last_q <= lrck_last_d;
      shift_q     <= shift_d;
      left_q      <= left_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      sound_q     <= sound_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
    end
  end

  assign sound = sound_q;
  assign valid = valid_q;
  assign error = error_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: builds SCK-period streams from slot lists and predicts frames and errors
// from the run structure of the sampled LRCK sequence.
module tb_i2s_rx;

  localparam int W  = 16;
  localparam int TO = 64;

  logic            clkin = 1'b0;
  logic            rst, sck, lrck, sd;
  logic [2*W-1:0]  sound;
  logic            valid, error;

  i2s_rx #(.WORD_BITS(W), .TIMEOUT(TO)) dut (
    .clkin(clkin),
    .rst  (rst),
    .sck  (sck),
    .lrck (lrck),
    .sd   (sd),
    .sound(sound),
    .valid(valid),
    .error(error)
  );

  always #5 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  bit             lr_q[$];
  bit             bit_q[$];
  logic [2*W-1:0] exp_q[$];
  int             exp_err, err_seen;
  int             last_rise_cyc, last_err_cyc, last_valid_cyc;
  bit             prev_lr;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic clear_stream();
    lr_q.delete();
    bit_q.delete();
  endtask

  task automatic add_slot(input bit lr, input int n, input logic [31:0] data);
    for (int i = n - 1; i >= 0; i--) begin
      lr_q.push_back(lr);
      bit_q.push_back(data[i]);
    end
  endtask

  task automatic add_frame(input logic [31:0] f);
    add_slot(1'b0, W, {16'h0, f[31:16]});
    add_slot(1'b1, W, {16'h0, f[15:0]});
  endtask

  // Philips format: data appears one SCK period after the LRCK change.
  function automatic bit sd_at(input int p);
    return (p == 0) ? 1'b0 : bit_q[p-1];
  endfunction

  function automatic logic [W-1:0] word_of(input int a, input int b);
    logic [W-1:0] w = '0;
    for (int e = a + 1; e <= b; e++) w = {w[W-2:0], sd_at(e)};
    return w;
  endfunction

  // Each LRCK run started by a change is a slot; a left/right pair of exactly W edges each
  // yields a frame. A stream that stops while locked ends in a timeout unless reset intervenes.
  task automatic run_model(input bit timeout_end);
    int starts[$];
    int k;
    logic [W-1:0] lw, rw;
    for (int p = 0; p < lr_q.size(); p++) begin
      if ((p == 0) ? (lr_q[0] != prev_lr) : (lr_q[p] != lr_q[p-1])) starts.push_back(p);
    end
    k = 0;
    while (k < starts.size()) begin
      if (lr_q[starts[k]]) begin
        k++;
      end else if (k + 1 >= starts.size()) begin
        if (timeout_end) exp_err++;
        k = starts.size();
      end else if (starts[k+1] - starts[k] != W) begin
        exp_err++;
        k++;
      end else if (k + 2 >= starts.size()) begin
        if (timeout_end) exp_err++;
        k = starts.size();
      end else if (starts[k+2] - starts[k+1] != W) begin
        exp_err++;
        k += 2;
      end else begin
        lw = word_of(starts[k], starts[k+1]);
        rw = word_of(starts[k+1], starts[k+2]);
        exp_q.push_back({lw, rw});
        k += 2;
      end
    end
    prev_lr = lr_q[lr_q.size()-1];
  endtask

  task automatic drive_stream(input int h);
    for (int p = 0; p < lr_q.size(); p++) begin
      sck  = 1'b0;
      lrck = lr_q[p];
      sd   = sd_at(p);
      wait_cyc(h);
      sck  = 1'b1;
      last_rise_cyc = cyc;
      wait_cyc(h);
    end
  endtask

  task automatic monitor();
    logic [2*W-1:0] want;
    forever begin
      @(negedge clkin);
      if (rst == 1'b0) begin
        if (valid) begin
          checks++;
          last_valid_cyc = cyc;
          if (error) begin
            errors++;
            $display("FAIL valid_error_overlap: valid=%b error=%b, required error=0", valid, error);
          end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: sound=%h, required no valid", sound);
          end else begin
            want = exp_q.pop_front();
            if (sound !== want) begin
              errors++;
              $display("FAIL frame_sound: got %h, required %h", sound, want);
            end
          end
        end
        if (error) begin
          err_seen++;
          last_err_cyc = cyc;
        end
      end
    end
  endtask

  task automatic begin_test();
    exp_q.delete();
    exp_err        = 0;
    err_seen       = 0;
    last_valid_cyc = -100000;
    last_err_cyc   = -100000;
  endtask

  task automatic finish_test(input string name);
    wait_cyc(TO + 20);
    checks++;
    if (err_seen !== exp_err) begin
      errors++;
      $display("FAIL %s_error_count: got %0d, required %0d", name, err_seen, exp_err);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_valid: %0d frames not seen, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sck = 1'b0; lrck = 1'b0; sd = 1'b0;
    wait_cyc(3);
    checks++;
    if (sound !== '0) begin
      errors++; $display("FAIL reset_sound: got %h, required 0", sound);
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b, required 0", valid);
    end
    checks++;
    if (error !== 1'b0) begin
      errors++; $display("FAIL reset_error: got %b, required 0", error);
    end
    rst = 1'b0;
    prev_lr = 1'b0;
  endtask

  task automatic test_basic();
    begin_test();
    clear_stream();
    add_slot(1'b1, 3, $urandom);
    add_frame(32'hA5C31234);
    add_slot(1'b0, 1, 0);
    run_model(1'b1);
    drive_stream(4);
    wait_cyc(8);
    checks++;
    if (last_valid_cyc - last_rise_cyc < 3 || last_valid_cyc - last_rise_cyc > 4) begin
      errors++;
      $display("FAIL basic_valid_latency: got %0d cycles, required 3..4",
               last_valid_cyc - last_rise_cyc);
    end
    checks++;
    if (err_seen != 0) begin
      errors++; $display("FAIL basic_no_error: got %0d errors, required 0", err_seen);
    end
    finish_test("basic");
    checks++;
    if (sound !== 32'hA5C31234) begin
      errors++; $display("FAIL basic_sound_hold: got %h, required a5c31234", sound);
    end
  endtask

  task automatic test_back_to_back();
    begin_test();
    clear_stream();
    add_slot(1'b1, 2, $urandom);
    add_frame(32'h00010002);
    add_frame(32'hFFFF8000);
    add_frame(32'h7FFF0001);
    add_slot(1'b0, 1, 0);
    run_model(1'b1);
    drive_stream(4);
    finish_test("back_to_back");
  endtask

  task automatic test_short_slot();
    begin_test();
    clear_stream();
    add_slot(1'b1, 4, $urandom);
    add_slot(1'b0, W, $urandom);
    add_slot(1'b1, W - 1, $urandom);
    add_frame(32'h11112222);
    add_slot(1'b0, 1, 0);
    run_model(1'b1);
    drive_stream(4);
    finish_test("short_slot");
    checks++;
    if (sound !== 32'h11112222) begin
      errors++; $display("FAIL short_slot_sound: got %h, required 11112222", sound);
    end
  endtask

  task automatic test_stall();
    begin_test();
    clear_stream();
    add_slot(1'b1, 2, $urandom);
    add_frame($urandom);
    add_slot(1'b0, 8, $urandom);
    run_model(1'b1);
    drive_stream(4);
    wait_cyc(100);
    checks++;
    if (last_err_cyc - last_rise_cyc < TO + 1 || last_err_cyc - last_rise_cyc > TO + 4) begin
      errors++;
      $display("FAIL stall_timeout_latency: got %0d cycles, required %0d..%0d",
               last_err_cyc - last_rise_cyc, TO + 1, TO + 4);
    end
    checks++;
    if (err_seen !== exp_err) begin
      errors++; $display("FAIL stall_timeout_count: got %0d, required %0d", err_seen, exp_err);
    end
    clear_stream();
    add_slot(1'b1, 3, $urandom);
    add_frame($urandom);
    add_slot(1'b0, 1, 0);
    run_model(1'b1);
    drive_stream(4);
    finish_test("stall");
  endtask

  task automatic test_reset_mid_word();
    begin_test();
    clear_stream();
    add_slot(1'b1, 2, $urandom);
    add_frame($urandom);
    add_slot(1'b0, W, $urandom);
    add_slot(1'b1, 8, $urandom);
    run_model(1'b0);
    drive_stream(4);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    checks++;
    if (sound !== '0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: sound=%h valid=%b, required 0 and 0", sound, valid);
    end
    prev_lr = 1'b0;
    clear_stream();
    add_slot(1'b1, W - 8, $urandom);
    add_frame($urandom);
    add_slot(1'b0, 1, 0);
    run_model(1'b1);
    drive_stream(4);
    finish_test("reset_mid_word");
  endtask

  task automatic test_min_ratio();
    begin_test();
    clear_stream();
    add_slot(1'b1, 2, $urandom);
    add_frame(32'hDEADBEEF);
    add_slot(1'b0, 1, 0);
    run_model(1'b1);
    drive_stream(2);
    wait_cyc(8);
    checks++;
    if (err_seen != 0) begin
      errors++; $display("FAIL min_ratio_no_error: got %0d errors, required 0", err_seen);
    end
    finish_test("min_ratio");
    checks++;
    if (sound !== 32'hDEADBEEF) begin
      errors++; $display("FAIL min_ratio_sound: got %h, required deadbeef", sound);
    end
  endtask

  task automatic test_random();
    int len_l, len_r;
    for (int it = 0; it < 4; it++) begin
      begin_test();
      clear_stream();
      add_slot(1'b1, $urandom_range(1, 4), $urandom);
      for (int f = 0; f < int'($urandom_range(3, 5)); f++) begin
        len_l = W;
        len_r = W;
        if ($urandom_range(0, 4) == 0) len_l = $urandom_range(0, 1) ? W + 1 : W - 1;
        if ($urandom_range(0, 4) == 0) len_r = $urandom_range(0, 1) ? W + 1 : W - 1;
        add_slot(1'b0, len_l, $urandom);
        add_slot(1'b1, len_r, $urandom);
      end
      add_slot(1'b0, 1, 0);
      run_model(1'b1);
      drive_stream($urandom_range(2, 5));
      finish_test("random");
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_back_to_back();
    test_short_slot();
    test_stall();
    test_reset_mid_word();
    test_min_ratio();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
